aes_inv_round_ctrl: RTL and testbench
=====================================

AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles to wait for op_ry per operation.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 start  input  1  SHALL request decryption of data_in; sampled only in IDLE.
REQ-005 data_in  input  128  SHALL carry the ciphertext block.
REQ-006 op_en  output  1  SHALL be the ClkEn to the shared step datapath.
REQ-007 op_sel  output  2  SHALL select the step: 0 AddRoundKey, 1 InvShiftRows, 2 InvSubBytes, 3 InvMixColumns.
REQ-008 op_data  output  128  SHALL carry the current state word to the step unit.
REQ-009 key_idx  output  4  SHALL give the round-key index (0..10) for AddRoundKey.
REQ-010 op_result  input  128  SHALL carry the step unit's dataOut.
REQ-011 op_ry  input  1  SHALL carry the step unit's Ry.
REQ-012 busy  output  1  SHALL be high from start acceptance until done or error.
REQ-013 done  output  1  SHALL be a one-cycle pulse marking valid data_out.
REQ-014 error  output  1  SHALL be a one-cycle pulse on op timeout.
REQ-015 data_out  output  128  SHALL hold the plaintext from done until the next accepted start.

Function
REQ-016 States SHALL be IDLE, EXEC, GAP, FINISH, FAIL.
REQ-017 IDLE with start=1 SHALL load data_in into the 128-bit state register, clear op counter (6 bits), go to EXEC.
REQ-018 Op sequence SHALL be ARK(10); for r=9..1: ISR, ISB, ARK(r), IMC; then ISR, ISB, ARK(0) -- 40 ops, indexed by op counter 0..39.
REQ-019 In EXEC, op_en=1 and op_sel/op_data/key_idx SHALL be stable, derived from op counter and state register.
REQ-020 In EXEC with op_ry=1, state register SHALL capture op_result that cycle, and FSM SHALL go to GAP.
REQ-021 GAP SHALL drive op_en=0 for exactly one cycle; then EXEC with counter+1, or FINISH if counter was 39.
REQ-022 With a zero-latency step unit (op_ry high in first EXEC cycle) start-to-done latency SHALL be exactly 81 cycles (1 load + 40x2).
REQ-023 FINISH SHALL copy state register to data_out, pulse done, drop busy, return to IDLE next cycle.
REQ-024 Timeout counter SHALL clear on EXEC entry; if TIMEOUT EXEC cycles pass without op_ry, go to FAIL.
REQ-025 FAIL SHALL pulse error, drive op_en=0, leave data_out unchanged, return to IDLE next cycle.
REQ-026 start while busy SHALL be ignored; start in the done cycle SHALL be ignored (accepted only from IDLE).
REQ-027 op_ry=1 in GAP or IDLE SHALL be ignored.
REQ-028 key_idx SHALL be 10 - (op_counter+3)/4 for ARK ops and don't-care (driven 0) otherwise.

Reset
REQ-029 rst=1 SHALL force IDLE and zero op_en, op_sel, op_data, key_idx, busy, done, error, data_out, state register and counters, including mid-operation.
REQ-030 First start SHALL be accepted the cycle after rst deasserts.

Structure
REQ-031 Shared package SHALL hold state encoding, op_sel codes (OP_ARK, OP_ISR, OP_ISB, OP_IMC), NUM_OPS=40, LAST_ROUND=10.
REQ-032 One sub-module aes_op_decode SHALL map op counter to op_sel and key_idx combinationally.

Verification
REQ-033 FIPS-197 C.1: data_in=69c4e0d86a7b0430d8cdb78070b4c55a, key 000102..0f, reference step model -> data_out=00112233445566778899aabbccddeeff, done at cycle 81.
REQ-034 Stub InvShiftRows-only check: op 1 with op_data=e241d05657b40e540f15940b00046a92 -> op_result captured unchanged into state; op_en low exactly one cycle after op_ry.
REQ-035 Step model delays op_ry by 3 cycles each op -> done at 1+40x5=201 cycles, same plaintext.
REQ-036 Step model withholds op_ry at op 17 -> error pulse after 16 EXEC cycles, busy=0, data_out unchanged, next start works.
REQ-037 rst asserted at op 20 -> all outputs 0 next cycle; fresh start yields correct C.1 plaintext.
REQ-038 start pulsed at cycles 5 and 40 of a run -> ignored, single done, op sequence/key_idx trace matches REQ-018.

Source files
------------

// File: rtl/aes_inv_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_round_ctrl_pkg
//  Description : Shared definitions for the AES-128 inverse-round sequencer:
//                FSM state encoding, step-select codes, sequence length and
//                the AddRoundKey key-index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_inv_round_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_GAP    = 3'd2,
        ST_FINISH = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    // Step selection codes presented on op_sel
    typedef enum logic [1:0] {
        OP_ARK = 2'd0,   // AddRoundKey
        OP_ISR = 2'd1,   // InvShiftRows
        OP_ISB = 2'd2,   // InvSubBytes
        OP_IMC = 2'd3    // InvMixColumns
    } op_sel_t;

    localparam int NUM_OPS    = 40;
    localparam int LAST_ROUND = 10;
    localparam int OP_CNT_W   = 6;
    localparam int KEY_IDX_W  = 4;
    localparam int BLOCK_W    = 128;

    // Round key used by the AddRoundKey op at sequence position op_cnt.
    // The ARK ops sit at positions 0, 3, 7, ..., 39, so (op_cnt+3)/4 counts
    // how many rounds have already been undone.
    function automatic logic [KEY_IDX_W-1:0] ark_key_idx(input logic [OP_CNT_W-1:0] op_cnt);
        int rounds_done;
        rounds_done = (int'(op_cnt) + 3) / 4;
        return KEY_IDX_W'(LAST_ROUND - rounds_done);
    endfunction

endpackage : aes_inv_round_ctrl_pkg
`default_nettype wire

// File: rtl/aes_inv_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_round_ctrl_if
//  Description : Bus between the inverse-round sequencer (master) and the
//                shared AES step datapath (slave).
//                  op_en     - clock enable to the step unit
//                  op_sel    - step select (ARK/ISR/ISB/IMC)
//                  op_data   - current 128-bit state word
//                  key_idx   - round-key index for AddRoundKey (0 otherwise)
//                  op_result - step unit dataOut
//                  op_ry     - step unit ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_round_ctrl_if;
    import aes_inv_round_ctrl_pkg::*;

    logic                  op_en;
    op_sel_t               op_sel;
    logic [BLOCK_W-1:0]    op_data;
    logic [KEY_IDX_W-1:0]  key_idx;
    logic [BLOCK_W-1:0]    op_result;
    logic                  op_ry;

    modport master (
        output op_en,
        output op_sel,
        output op_data,
        output key_idx,
        input  op_result,
        input  op_ry
    );

    modport slave (
        input  op_en,
        input  op_sel,
        input  op_data,
        input  key_idx,
        output op_result,
        output op_ry
    );

endinterface : aes_inv_round_ctrl_if
`default_nettype wire

// File: rtl/aes_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : aes_op_decode
//  Description : Combinational map from op counter (0..39) to step select and
//                round-key index. Sequence:
//                  ARK(10); r=9..1: ISR, ISB, ARK(r), IMC; ISR, ISB, ARK(0)
//  Ports       : op_cnt  (in)  - position in the 40-op sequence
//                op_sel  (out) - step select
//                key_idx (out) - round key for ARK, 0 for other steps
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_op_decode
    import aes_inv_round_ctrl_pkg::*;
(
    input  wire logic [OP_CNT_W-1:0]  op_cnt,
    output op_sel_t                   op_sel,
    output logic [KEY_IDX_W-1:0]      key_idx
);

    always_comb begin
        op_sel  = OP_ARK;
        key_idx = '0;
        if (op_cnt == '0) begin
            op_sel = OP_ARK;
        end else begin
            // After the leading ARK the sequence repeats with period 4,
            // phase-aligned so that op 1 is ISR.
            case (op_cnt[1:0])
                2'd1:    op_sel = OP_ISR;
                2'd2:    op_sel = OP_ISB;
                2'd3:    op_sel = OP_ARK;
                default: op_sel = OP_IMC;
            endcase
        end
        if (op_sel == OP_ARK) begin
            key_idx = ark_key_idx(op_cnt);
        end
    end

endmodule : aes_op_decode
`default_nettype wire

// File: rtl/aes_inv_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_round_ctrl
//  Description : Sequencer for AES-128 decryption over a shared step
//                datapath. Loads a ciphertext block, issues 40 steps one at a
//                time (each followed by a one-cycle idle gap), and returns
//                the plaintext. Aborts with an error pulse when the step unit
//                fails to answer within TIMEOUT cycles.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start, data_in    - request and ciphertext (IDLE only)
//                op_bus            - master side of the step-unit bus
//                busy              - operation in progress
//                done              - one-cycle pulse, data_out valid
//                error             - one-cycle pulse on step timeout
//                data_out          - plaintext, held until next start
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_round_ctrl
    import aes_inv_round_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start,
    input  wire logic [BLOCK_W-1:0]  data_in,
    aes_inv_round_ctrl_if.master     op_bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [BLOCK_W-1:0]       data_out
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t                 r_state;
    logic [BLOCK_W-1:0]     r_blk;
    logic [OP_CNT_W-1:0]    r_op_cnt;
    logic [TO_W-1:0]        r_to_cnt;

    logic [OP_CNT_W-1:0]    w_dec_cnt;
    op_sel_t                w_dec_sel;
    logic [KEY_IDX_W-1:0]   w_dec_key;

    // The step outputs are registered, so they are decoded for the op that
    // is about to start: op 0 when leaving IDLE, the following op otherwise.
    assign w_dec_cnt = (r_state == ST_IDLE) ? '0 : (r_op_cnt + OP_CNT_W'(1));

    aes_op_decode u_op_decode (
        .op_cnt  (w_dec_cnt),
        .op_sel  (w_dec_sel),
        .key_idx (w_dec_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_blk          <= '0;
            r_op_cnt       <= '0;
            r_to_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            data_out       <= '0;
            op_bus.op_en   <= 1'b0;
            op_bus.op_sel  <= OP_ARK;
            op_bus.op_data <= '0;
            op_bus.key_idx <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_blk          <= data_in;
                        r_op_cnt       <= '0;
                        r_to_cnt       <= '0;
                        busy           <= 1'b1;
                        op_bus.op_en   <= 1'b1;
                        op_bus.op_sel  <= w_dec_sel;
                        op_bus.key_idx <= w_dec_key;
                        op_bus.op_data <= data_in;
                        r_state        <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (op_bus.op_ry) begin
                        r_blk        <= op_bus.op_result;
                        op_bus.op_en <= 1'b0;
                        r_state      <= ST_GAP;
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        // This is the last permitted EXEC cycle for this op.
                        op_bus.op_en <= 1'b0;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                        r_state      <= ST_FAIL;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                ST_GAP: begin
                    if (r_op_cnt == OP_CNT_W'(NUM_OPS - 1)) begin
                        data_out <= r_blk;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_FINISH;
                    end else begin
                        r_op_cnt       <= r_op_cnt + OP_CNT_W'(1);
                        r_to_cnt       <= '0;
                        op_bus.op_en   <= 1'b1;
                        op_bus.op_sel  <= w_dec_sel;
                        op_bus.key_idx <= w_dec_key;
                        op_bus.op_data <= r_blk;
                        r_state        <= ST_EXEC;
                    end
                end

                // done/error are already high for this single cycle;
                // start is not sampled here.
                ST_FINISH: r_state <= ST_IDLE;
                ST_FAIL:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : aes_inv_round_ctrl
`default_nettype wire

// File: tb/tb_aes_inv_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_round_ctrl
//  Description : Self-checking bench for aes_inv_round_ctrl. A behavioural
//                AES step unit answers the controller with configurable
//                latency; results are compared with an independent
//                AES-128 decryption model and the FIPS-197 C.1 vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_round_ctrl;
    import aes_inv_round_ctrl_pkg::*;

    localparam int TIMEOUT = 16;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] STUB_V = 128'he241d05657b40e540f15940b00046a92;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] data_in = '0;
    logic         busy, done, error;
    logic [127:0] data_out;

    aes_inv_round_ctrl_if op_bus ();

    aes_inv_round_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .op_bus   (op_bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic void expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = gb(s, r + 4*((c - r + 4) % 4));
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = isbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127 - 8*(4*c)   -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
            o[127 - 8*(4*c+1) -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
            o[127 - 8*(4*c+2) -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
            o[127 - 8*(4*c+3) -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] step(input logic [1:0] sel, input logic [127:0] d, input logic [3:0] k);
        case (sel)
            2'd0:    return (k <= 4'd10) ? (d ^ rk[k]) : d;
            2'd1:    return inv_shift_rows(d);
            2'd2:    return inv_sub_bytes(d);
            default: return inv_mix_columns(d);
        endcase
    endfunction

    // Textbook AES-128 inverse cipher
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 1; r--)
            s = inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ rk[r]);
        return inv_sub_bytes(inv_shift_rows(s)) ^ rk[0];
    endfunction

    // ---------------- behavioural step unit ----------------
    int           lat_tab [40];
    int           withhold_op = -1;
    bit           stub_mode = 1'b0;
    bit           noise = 1'b0;
    logic [127:0] cur_din = '0;
    int           op_idx = 0;
    int           exec_cyc = 0;
    bit           prev_en = 1'b0;
    int           gap_len = 0;
    logic [127:0] last_res = '0;
    logic [127:0] rec_data = '0;
    int           tr_sel [$];
    int           tr_key [$];
    logic         m_ry;
    logic [127:0] m_res;

    always @(negedge clk) begin
        if (!busy) begin
            op_idx  = 0;
            gap_len = 0;
        end
        m_ry  = 1'b0;
        m_res = {$urandom, $urandom, $urandom, $urandom};
        if (op_bus.op_en) begin
            if (!prev_en) begin
                if (op_idx == 0) begin
                    tr_sel.delete();
                    tr_key.delete();
                    check("op0_data", op_bus.op_data, cur_din);
                end else begin
                    check("gap_len", 128'(gap_len), 128'd1);
                    check("op_data_chain", op_bus.op_data, last_res);
                end
                tr_sel.push_back(int'(op_bus.op_sel));
                tr_key.push_back(int'(op_bus.key_idx));
                rec_data = op_bus.op_data;
                exec_cyc = 0;
            end else begin
                exec_cyc++;
                check("op_data_hold", op_bus.op_data, rec_data);
            end
            m_ry = (exec_cyc >= ((op_idx < 40) ? lat_tab[op_idx] : 0)) && (op_idx != withhold_op);
            if (stub_mode) m_res = (op_idx == 0) ? STUB_V : op_bus.op_data;
            else           m_res = step(op_bus.op_sel, op_bus.op_data, op_bus.key_idx);
            if (m_ry) begin
                last_res = m_res;
                op_idx++;
            end
            gap_len = 0;
        end else begin
            if (busy) gap_len++;
            m_ry = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        op_bus.op_ry     = m_ry;
        op_bus.op_result = m_res;
        prev_en          = op_bus.op_en;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int set_lat(input int lo, input int hi);
        int sum = 1;
        for (int i = 0; i < 40; i++) begin
            lat_tab[i] = int'($urandom_range(hi, lo));
            sum += lat_tab[i] + 2;
        end
        return sum;
    endfunction

    task automatic check_trace(input string tag);
        int es [$];
        int ek [$];
        es.push_back(0); ek.push_back(10);
        for (int r = 9; r >= 1; r--) begin
            es.push_back(1); ek.push_back(0);
            es.push_back(2); ek.push_back(0);
            es.push_back(0); ek.push_back(r);
            es.push_back(3); ek.push_back(0);
        end
        es.push_back(1); ek.push_back(0);
        es.push_back(2); ek.push_back(0);
        es.push_back(0); ek.push_back(0);
        check({tag, "_trace_len"}, 128'(tr_sel.size()), 128'd40);
        for (int i = 0; i < 40 && i < tr_sel.size(); i++) begin
            check({tag, "_op_sel"},  128'(tr_sel[i]), 128'(es[i]));
            check({tag, "_key_idx"}, 128'(tr_key[i]), 128'(ek[i]));
        end
    endtask

    // One complete decryption; expects done at exp_cyc cycles after start.
    task automatic run(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt,
                       input int exp_cyc, input bit pulses);
        int cyc;
        cur_din = ct;
        data_in = ct;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (cyc < 400 && !done && !error) begin
            start = pulses && (cyc == 5 || cyc == 40);
            if (start) data_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done"},    128'(done), 128'd1);
        check({tag, "_latency"}, 128'(cyc), 128'(exp_cyc));
        check({tag, "_data_out"}, data_out, exp_pt);
        check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
        check({tag, "_no_error"}, 128'(error), 128'd0);
        check_trace(tag);
        // start coinciding with done must not be taken
        start   = 1'b1;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        check({tag, "_done_pulse"}, 128'(done), 128'd0);
        check({tag, "_start_in_done_ignored"}, 128'(busy), 128'd0);
        check({tag, "_op_en_idle"}, 128'(op_bus.op_en), 128'd0);
        check({tag, "_data_out_held"}, data_out, exp_pt);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     128'(busy), 128'd0);
        check({tag, "_done"},     128'(done), 128'd0);
        check({tag, "_error"},    128'(error), 128'd0);
        check({tag, "_data_out"}, data_out, 128'd0);
        check({tag, "_op_en"},    128'(op_bus.op_en), 128'd0);
        check({tag, "_op_sel"},   128'(op_bus.op_sel), 128'd0);
        check({tag, "_op_data"},  op_bus.op_data, 128'd0);
        check({tag, "_key_idx"},  128'(op_bus.key_idx), 128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cyc;
        int cyc;
        bit seen_done;
        logic [127:0] prev_out;
        logic [127:0] key;
        logic [127:0] ct;

        build_sbox();
        expand_key(C1_KEY);
        void'(set_lat(0, 0));

        repeat (3) tick();
        check_zero("reset");

        // first start in the cycle reset is released
        rst = 1'b0;
        run("c1", C1_CT, C1_PT, 81, 1'b0);

        // stray starts mid-run
        run("c1_pulses", C1_CT, C1_PT, 81, 1'b1);

        // three-cycle step latency
        void'(set_lat(3, 3));
        run("c1_lat3", C1_CT, C1_PT, 201, 1'b0);

        // identity stub: captured result flows through unchanged
        void'(set_lat(0, 0));
        stub_mode = 1'b1;
        run("stub_isr", C1_CT, STUB_V, 81, 1'b0);
        stub_mode = 1'b0;

        // randomized blocks, keys and latencies with ready noise outside EXEC
        noise = 1'b1;
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            exp_cyc = set_lat(0, 3);
            run($sformatf("rand%0d", n), ct, ref_decrypt(ct), exp_cyc, n[0]);
        end
        noise = 1'b0;

        // timeout: op 17 never answers
        expand_key(C1_KEY);
        void'(set_lat(0, 0));
        withhold_op = 17;
        prev_out = data_out;
        cur_din  = C1_CT;
        data_in  = C1_CT;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        seen_done = 1'b0;
        while (cyc < 200 && !error) begin
            if (done) seen_done = 1'b1;
            tick();
            cyc++;
        end
        check("to_error", 128'(error), 128'd1);
        check("to_latency", 128'(cyc), 128'd51);
        check("to_busy", 128'(busy), 128'd0);
        check("to_op_en", 128'(op_bus.op_en), 128'd0);
        check("to_data_out", data_out, prev_out);
        check("to_no_done", 128'(seen_done), 128'd0);
        tick();
        check("to_error_pulse", 128'(error), 128'd0);
        withhold_op = -1;
        run("after_to", C1_CT, C1_PT, 81, 1'b0);

        // reset in the middle of a run
        cur_din = C1_CT;
        data_in = C1_CT;
        start   = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 200 && op_idx < 20) begin
            tick();
            cyc++;
        end
        check("rst_reach_op20", 128'(op_idx), 128'd20);
        rst = 1'b1;
        tick();
        check_zero("mid_rst");
        rst = 1'b0;
        run("after_rst", C1_CT, C1_PT, 81, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_aes_inv_round_ctrl
`default_nettype wire
